// File: rtl/serialtl_mem_responder.sv
`default_nettype none
// serialtl_mem_responder: services SerialTL A-channel Get/Put frames against a 64-bit RAM and returns D-channel acks.
// Optional macro STL_RESP_PARTIAL_PUT_EN enables PutPartialData byte-mask writes; otherwise opcode 1 is denied.
module serialtl_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [63:0] ADDR_BASE   = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [2:0]  a_chanId,
  input  logic [2:0]  a_opcode,
  input  logic [2:0]  a_param,
  input  logic [7:0]  a_size,
  input  logic [7:0]  a_source,
  input  logic [63:0] a_address,
  input  logic [63:0] a_data,
  input  logic        a_corrupt,
  input  logic [8:0]  a_union,
  input  logic        a_last,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [2:0]  d_chanId,
  output logic [2:0]  d_opcode,
  output logic [2:0]  d_param,
  output logic [7:0]  d_size,
  output logic [7:0]  d_source,
  output logic [63:0] d_address,
  output logic [63:0] d_data,
  output logic        d_corrupt,
  output logic [8:0]  d_union,
  output logic        d_last,
  output logic [15:0] debug_req_count,
  output logic [7:0]  debug_err_count,
  output logic [1:0]  debug_state
);

  localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
  localparam int unsigned BYTE_AW = IDX_W + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [63:0]      mem [DEPTH_WORDS];
  logic [2:0]       req_op;
  logic [7:0]       req_size;
  logic [7:0]       req_source;
  logic [IDX_W-1:0] req_idx;
  logic [63:0]      req_data;
  logic [7:0]       req_mask;
  logic             req_denied;

  logic       accept;
  logic       in_range;
  logic       misaligned;
  logic       bad_op;
  logic       is_put;
  logic       dec_denied;
  logic [2:0] align_mask;
  logic [7:0] lane_mask;
  logic [7:0] wr_mask;
  logic       err_inc;
  logic       unused;

`ifdef STL_RESP_PARTIAL_PUT_EN
  assign unused = ^{a_param, a_union[8]};
`else
  assign unused = ^{a_param, a_union};
`endif

  assign accept = a_valid & a_ready;

  // Base is range-aligned, so the range test reduces to matching the upper address bits.
  always_comb begin
    in_range   = (a_address[63:BYTE_AW] == ADDR_BASE[63:BYTE_AW]);
    align_mask = 3'b000;
    lane_mask  = 8'h01 << a_address[2:0];
    case (a_size[1:0])
      2'd1: begin align_mask = 3'b001; lane_mask = 8'h03 << a_address[2:0]; end
      2'd2: begin align_mask = 3'b011; lane_mask = 8'h0F << a_address[2:0]; end
      2'd3: begin align_mask = 3'b111; lane_mask = 8'hFF << a_address[2:0]; end
      default: ;
    endcase
    misaligned = |(a_address[2:0] & align_mask);
    is_put     = (a_opcode == 3'd0) || (a_opcode == 3'd1);
`ifdef STL_RESP_PARTIAL_PUT_EN
    bad_op  = !(is_put || (a_opcode == 3'd4));
    wr_mask = (a_opcode == 3'd1) ? (lane_mask & a_union[7:0]) : lane_mask;
`else
    bad_op  = !((a_opcode == 3'd0) || (a_opcode == 3'd4));
    wr_mask = lane_mask;
`endif
    dec_denied = !in_range || (a_size > 8'd3) || misaligned || (a_corrupt && is_put) || bad_op;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    a_ready     = 1'b0;
    d_valid     = 1'b0;
    case (state)
      IDLE: begin
        a_ready = reset;
        if (accept && (a_chanId == 3'd0))
          state_nxt = ((a_size > 8'd3) && !a_last) ? DRAIN : EXEC;
      end
      DRAIN: begin
        a_ready = reset;
        if (accept && a_last) state_nxt = EXEC;
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        d_valid = 1'b1;
        if (d_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign d_last      = d_valid;
  assign debug_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_op          <= '0;
      req_size        <= '0;
      req_source      <= '0;
      req_idx         <= '0;
      req_data        <= '0;
      req_mask        <= '0;
      req_denied      <= 1'b0;
      d_chanId        <= '0;
      d_opcode        <= '0;
      d_param         <= '0;
      d_size          <= '0;
      d_source        <= '0;
      d_address       <= '0;
      d_data          <= '0;
      d_corrupt       <= 1'b0;
      d_union         <= '0;
      debug_req_count <= '0;
      debug_err_count <= '0;
    end else begin
      if ((state == IDLE) && accept && (a_chanId == 3'd0)) begin
        req_op          <= a_opcode;
        req_size        <= a_size;
        req_source      <= a_source;
        req_idx         <= a_address[BYTE_AW-1:3];
        req_data        <= a_data;
        req_mask        <= wr_mask;
        req_denied      <= dec_denied;
        debug_req_count <= debug_req_count + 16'd1;
      end
      // Beats of an oversized burst are discarded; the whole frame is refused.
      if ((state == DRAIN) && accept && a_last) req_denied <= 1'b1;
      if (state == EXEC) begin
        d_chanId  <= 3'd3;
        d_param   <= 3'd0;
        d_opcode  <= (req_op == 3'd4) ? 3'd1 : 3'd0;
        d_size    <= req_size;
        d_source  <= req_source;
        d_address <= '0;
        d_data    <= ((req_op == 3'd4) && !req_denied) ? mem[req_idx] : 64'd0;
        d_corrupt <= req_denied && (req_op == 3'd4);
        d_union   <= {8'd0, req_denied};
      end
      if (err_inc && (debug_err_count != 8'hFF))
        debug_err_count <= debug_err_count + 8'd1;
    end
  end

  assign err_inc = ((state == IDLE) && accept && (a_chanId != 3'd0)) ||
                   ((state == EXEC) && req_denied);

  always_ff @(posedge clk) begin
    if ((state == EXEC) && !req_denied && (req_op != 3'd4)) begin
      for (int k = 0; k < 8; k++)
        if (req_mask[k]) mem[req_idx][8*k +: 8] <= req_data[8*k +: 8];
    end
  end

endmodule
`default_nettype wire

// File: doc/serialtl_mem_responder.md
Name: serialtl_mem_responder

Overview:
- Managing-side endpoint for SerialTL bring-up.
- Accepts deserialized TileLink A-channel frames: Get, PutFullData and PutPartialData.
- Services each frame against an internal 64-bit-wide RAM and emits D-channel response frames to a serializer.
- Used as the FPGA-side loopback target that stands in for the SCuM-V memory when we validate the host STL path without silicon.

Parameters:
- DEPTH_WORDS, 256: RAM depth in 64-bit words; power of two, at least 2.
- ADDR_BASE, 64'h0000_0000_8000_0000: first byte address served. Must be DEPTH_WORDS*8-aligned.

Ports:
- clk  in  1  Sole clock.
- reset  in  1  Asynchronous, active-low reset (asserted at 0).
- a_valid  in  1  A-frame valid.
- a_ready  out  1  A-frame accepted when a_valid & a_ready.
- a_chanId, a_opcode, a_param  in  3 each  A-frame fields.
- a_size, a_source  in  8 each  log2 bytes; transaction ID.
- a_address, a_data  in  64 each  Byte address; write data.
- a_corrupt  in  1  Corrupt flag.
- a_union  in  9  Bits [7:0] are the byte mask.
- a_last  in  1  Last beat of frame.
- d_valid  out  1  D-frame valid.
- d_ready  in  1  D-frame consumed when d_valid & d_ready.
- d_chanId, d_opcode, d_param  out  3 each  D-frame fields.
- d_size, d_source  out  8 each  Echoed from request.
- d_address, d_data  out  64 each  d_address is always 0; d_data is read data.
- d_corrupt  out  1  Set on a denied Get.
- d_union  out  9  Bit 0 is denied; bits [8:1] are 0.
- d_last  out  1  Always 1 while d_valid.
- debug_req_count  out  16  Accepted chanId==0 frames; wraps modulo 2^16.
- debug_err_count  out  8  Denied or dropped frames; saturates at 255.
- debug_state  out  2  Encoded FSM state.

Behaviour:
- Reset values (reset==0, asynchronous):
  - state=IDLE; a_ready=0 while reset is asserted.
  - d_valid=0, all d_* fields 0; both counters 0.
  - RAM contents are not reset.
- FSM states and encodings:
  - IDLE(0): a_ready=1.
    - On accept with chanId!=0: frame dropped, err_count++, stay in IDLE.
    - On accept with chanId==0: latch fields, req_count++, go to EXEC. If a_size>3 and a_last=0, go to DRAIN instead.
  - DRAIN(3): a_ready=1. Beats are discarded until an accepted beat has a_last=1, then go to EXEC with denied=1.
  - EXEC(1): a_ready=0. Perform a single RAM access (write, or registered read), then go to RESP.
  - RESP(2): d_valid=1. Fields are held stable until d_ready; go to IDLE on the handshake.
- Latency: accept at cycle T gives d_valid at T+2. With d_ready held high, the next accept is at T+3. At most one transaction is outstanding.
- Decode:
  - Word index = (address - ADDR_BASE) >> 3.
  - denied=1 when any of:
    - address < ADDR_BASE, or address >= ADDR_BASE + DEPTH_WORDS*8;
    - size>3;
    - address not aligned to 2^size;
    - a_corrupt=1 on a Put;
    - opcode not in {0,1,4}.
- Lane mask:
  - PutFull: the 2^size bytes starting at lane address[2:0].
  - PutPartial: lane mask AND a_union[7:0].
  - Byte lane k maps to data[8k+7:8k].
- Opcodes:
  - Get(4): response d_opcode=1 (AccessAckData) with d_data = full 64-bit word.
  - Put(0/1): response d_opcode=0 (AccessAck) with d_data=0.
- All responses: d_chanId=3, d_param=0, d_size and d_source echoed.
- Denied requests:
  - No RAM write occurs.
  - d_union[0]=1; err_count increments.
  - Denied Get: d_corrupt=1, d_data=0.
- Simultaneous events: counter increments in the same cycle commit independently. Saturation takes priority over increment.
- Reset asserted mid-transaction: response abandoned, d_valid drops immediately, no partial RAM write.

Optional Feature:
- Macro: STL_RESP_PARTIAL_PUT_EN.
- Defined: PutPartialData (opcode 1) honours the a_union[7:0] mask as described above.
- Undefined: opcode 1 is denied (no write; AccessAck with d_union[0]=1; err_count++). The mask logic is removed.

Test Plan:
- PutFull, size 3, at 0x8000_0010 with data 0x1122334455667788, then Get of the same address -> AccessAck (union 0), then AccessAckData with d_data 0x1122334455667788 and source echoed. d_valid rises exactly 2 cycles after each accept.
- Get at 0x7FFF_FFF8 and at 0x8000_0800 (DEPTH=256) -> both return d_union[0]=1, d_corrupt=1, d_data=0; err_count=2; RAM unchanged.
- PutFull, size 1, at 0x8000_0012 with data 0x0000_0000_ABCD_0000 over a word of all 0xFF -> read back 0xFFFF_FFFF_ABCD_FFFF. Misaligned size 2 at 0x8000_0002 -> denied.
- d_ready held 0 for 10 cycles during RESP -> d_* stable, a_ready=0; then release -> single handshake, a_ready=1 the next cycle.
- 3-beat Put with size 5 and last on beat 3 -> exactly one denied AccessAck after beat 3; req_count +1.
- With the macro defined: PutPartial with mask 0x0F and data 0xDEADBEEF_CAFEF00D over 0 -> read back 0x0000_0000_CAFEF00D. Without the macro: the same stimulus is denied and the word stays 0.
